bcd_bin_convert: RTL and testbench

BCD_BIN_CONVERT -- requirements
Module: bcd_bin_convert

---
 rtl/bcd_pkg.sv | 27 ++
 rtl/bcd_digit_adj.sv | 10 +
 rtl/bcd_bin_convert.sv | 92 +++++++++
 tb/tb_bcd_bin_convert.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared types and constants for the BCD-to-binary converter.
// Holds the FSM encoding, sizing constants and the range check.
package bcd_pkg;

    localparam int BCD_DIGITS = 3;
    localparam int BIN_W      = 8;
    localparam int WORK_W     = 20;
    localparam int BIN_MAX    = 255;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CHECK  = 3'd1,
        SHIFT  = 3'd2,
        ADJUST = 3'd3,
        DONE   = 3'd4
    } state_t;

    // Digits are {hundreds, tens, units}; flags non-BCD or out-of-range input.
    function automatic logic bcd_invalid(input logic [11:0] bcd);
        logic [9:0] value;
        logic       bad_digit;
        bad_digit = (bcd[11:8] > 4'd9) || (bcd[7:4] > 4'd9) || (bcd[3:0] > 4'd9);
        value = 10'(bcd[11:8]) * 10'd100 + 10'(bcd[7:4]) * 10'd10 + 10'(bcd[3:0]);
        return bad_digit || (value > 10'(BIN_MAX));
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// One BCD nibble correction step for reverse double-dabble.
// Subtracts 3 when the nibble is 8 or more; cannot underflow.
module bcd_digit_adj (
    input  logic [3:0] din,
    output logic [3:0] dout
);

    assign dout = (din >= 4'd8) ? (din - 4'd3) : din;

endmodule

// File: rtl/bcd_bin_convert.sv
// Three-digit BCD to 8-bit binary converter using reverse double-dabble.
// Eight shift/adjust pairs per conversion; out-of-range input reports err.
module bcd_bin_convert
    import bcd_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic [3:0]       fdig,
    input  logic [3:0]       sdig,
    input  logic [3:0]       tdig,
    output logic [BIN_W-1:0] bin_d_out,
    output logic             rdy,
    output logic             err,
    output logic             busy
);

    state_t state;
    state_t next;

    logic [WORK_W-1:0] work;
    logic [2:0]        cnt;
    logic              err_flag;
    logic [11:0]       adj;

    for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .din  (work[BIN_W + 4*g +: 4]),
            .dout (adj[4*g +: 4])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next;
    end

    always_comb begin
        next = state;
        unique case (state)
            IDLE:    if (ena) next = CHECK;
            CHECK:   next = bcd_invalid(work[WORK_W-1:BIN_W]) ? DONE : SHIFT;
            SHIFT:   next = ADJUST;
            // Counter wraps to zero after the eighth shift.
            ADJUST:  next = (cnt != 3'd0) ? SHIFT : DONE;
            DONE:    next = IDLE;
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            work      <= '0;
            cnt       <= '0;
            err_flag  <= 1'b0;
            bin_d_out <= '0;
            rdy       <= 1'b0;
            err       <= 1'b0;
            busy      <= 1'b0;
        end else begin
            rdy <= 1'b0;
            case (state)
                IDLE: begin
                    if (ena) begin
                        work     <= {tdig, sdig, fdig, {BIN_W{1'b0}}};
                        cnt      <= '0;
                        err_flag <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                CHECK: begin
                    err_flag <= bcd_invalid(work[WORK_W-1:BIN_W]);
                end
                SHIFT: begin
                    work <= work >> 1;
                    cnt  <= cnt + 3'd1;
                end
                ADJUST: begin
                    work <= {adj, work[BIN_W-1:0]};
                end
                DONE: begin
                    bin_d_out <= err_flag ? '0 : work[BIN_W-1:0];
                    err       <= err_flag;
                    rdy       <= 1'b1;
                    busy      <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_bin_convert.sv
// Self-checking bench for bcd_bin_convert against an arithmetic model.
// Covers reset, fixed and random vectors, errors, abort and a full sweep.
module tb_bcd_bin_convert;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ena = 1'b0;
    logic [3:0] fdig = '0;
    logic [3:0] sdig = '0;
    logic [3:0] tdig = '0;
    logic [7:0] bin_d_out;
    logic       rdy;
    logic       err;
    logic       busy;

    int tests = 0;
    int fails = 0;

    bcd_bin_convert dut (
        .clk       (clk),
        .rst       (rst),
        .ena       (ena),
        .fdig      (fdig),
        .sdig      (sdig),
        .tdig      (tdig),
        .bin_d_out (bin_d_out),
        .rdy       (rdy),
        .err       (err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic void model(input int t, input int s, input int f,
                                  output logic [7:0] v, output logic e,
                                  output int lat);
        int n;
        n   = t * 100 + s * 10 + f;
        e   = (t > 9) || (s > 9) || (f > 9) || (n > 255);
        v   = e ? 8'h00 : 8'(n);
        lat = e ? 2 : 18;
    endfunction

    // Starts one conversion and reports result, edges from capture to rdy,
    // and whether rdy dropped again on the following edge.
    task automatic run_conv(input logic [3:0] t, input logic [3:0] s,
                            input logic [3:0] f, output logic [7:0] out,
                            output logic e, output int lat,
                            output logic width_ok);
        @(negedge clk);
        tdig = t; sdig = s; fdig = f; ena = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ena = 1'b0;
        lat = -1; out = '0; e = 1'b0; width_ok = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (rdy) begin
                lat = i; out = bin_d_out; e = err;
                break;
            end
        end
        if (lat > 0) begin
            @(posedge clk); #1;
            width_ok = !rdy;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; ena = 1'b1; tdig = 4'd2; sdig = 4'd5; fdig = 4'd5;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if ({bin_d_out, rdy, err, busy} !== 11'd0) begin
            fails++;
            $display("FAIL reset_outputs got out=%h rdy=%b err=%b busy=%b want all 0",
                     bin_d_out, rdy, err, busy);
        end
        @(negedge clk);
        ena = 1'b0; rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (busy !== 1'b0 || rdy !== 1'b0) begin
            fails++;
            $display("FAIL reset_no_start got busy=%b rdy=%b want 0 0", busy, rdy);
        end
    endtask

    task automatic check_conv(input string name, input logic [11:0] bcd);
        logic [7:0] out, ev;
        logic       e, ee, w;
        int         lat, el;
        model(int'(bcd[11:8]), int'(bcd[7:4]), int'(bcd[3:0]), ev, ee, el);
        run_conv(bcd[11:8], bcd[7:4], bcd[3:0], out, e, lat, w);
        tests++;
        if (out !== ev || e !== ee) begin
            fails++;
            $display("FAIL %s_%h got out=%h err=%b want out=%h err=%b",
                     name, bcd, out, e, ev, ee);
        end
        tests++;
        if (lat != el) begin
            fails++;
            $display("FAIL %s_%h_latency got %0d want %0d", name, bcd, lat, el);
        end
        tests++;
        if (w !== 1'b1) begin
            fails++;
            $display("FAIL %s_%h_rdy_width got rdy still high want 1-cycle pulse",
                     name, bcd);
        end
    endtask

    task automatic test_vectors;
        logic [11:0] vec [6];
        vec = '{12'h255, 12'h128, 12'h000, 12'h009, 12'h100, 12'h099};
        foreach (vec[i]) check_conv("vector", vec[i]);
    endtask

    task automatic test_errors;
        logic [11:0] vec [5];
        vec = '{12'h256, 12'h0A0, 12'h300, 12'h260, 12'hF00};
        foreach (vec[i]) check_conv("error", vec[i]);
    endtask

    task automatic test_random;
        logic [11:0] bcd;
        int n;
        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                bcd = 12'($urandom_range(0, 4095));
            end else begin
                n   = $urandom_range(0, 255);
                bcd = {4'(n / 100), 4'((n / 10) % 10), 4'(n % 10)};
            end
            check_conv("random", bcd);
        end
    endtask

    task automatic test_midchange;
        int pulses = 0;
        int first = -1;
        logic [7:0] val = '0;
        @(negedge clk);
        tdig = 4'd1; sdig = 4'd2; fdig = 4'd8; ena = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ena = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (rdy) begin
                pulses++;
                if (first < 0) begin
                    first = i; val = bin_d_out;
                end
            end
            if (i == 4) begin
                tdig = 4'd0; sdig = 4'd9; fdig = 4'd9; ena = 1'b1;
            end
            if (i == 6) ena = 1'b0;
        end
        tests++;
        if (pulses != 1) begin
            fails++;
            $display("FAIL midchange_pulses got %0d want 1", pulses);
        end
        tests++;
        if (val !== 8'h80 || first != 18) begin
            fails++;
            $display("FAIL midchange_result got out=%h lat=%0d want out=80 lat=18",
                     val, first);
        end
    endtask

    task automatic test_reset_abort;
        logic [7:0] out;
        logic       e, w;
        int         lat;
        int         stray = 0;
        @(negedge clk);
        tdig = 4'd2; sdig = 4'd5; fdig = 4'd5; ena = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ena = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        tests++;
        if ({bin_d_out, rdy, err, busy} !== 11'd0) begin
            fails++;
            $display("FAIL abort_outputs got out=%h rdy=%b err=%b busy=%b want all 0",
                     bin_d_out, rdy, err, busy);
        end
        rst = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk); #1;
            if (rdy) stray++;
        end
        tests++;
        if (stray != 0) begin
            fails++;
            $display("FAIL abort_no_rdy got %0d pulses want 0", stray);
        end
        run_conv(4'd1, 4'd0, 4'd0, out, e, lat, w);
        tests++;
        if (out !== 8'h64 || e !== 1'b0 || lat != 18) begin
            fails++;
            $display("FAIL abort_then_100 got out=%h err=%b lat=%0d want 64 0 18",
                     out, e, lat);
        end
    endtask

    // Capture-to-capture with ena held: 18 edges to DONE plus one IDLE edge.
    task automatic test_back_to_back;
        int edges = 0;
        int last = -1;
        logic got;
        @(negedge clk);
        tdig = 4'd0; sdig = 4'd0; fdig = 4'd0; ena = 1'b1;
        for (int v = 0; v <= 255; v++) begin
            got = 1'b0;
            for (int i = 0; i < 40; i++) begin
                @(posedge clk); #1;
                edges++;
                if (rdy) begin
                    got = 1'b1;
                    break;
                end
            end
            tests++;
            if (!got) begin
                fails++;
                $display("FAIL sweep_timeout value=%0d got no rdy want rdy", v);
                break;
            end
            if (bin_d_out !== 8'(v) || err !== 1'b0) begin
                fails++;
                $display("FAIL sweep_value got out=%h err=%b want out=%h err=0",
                         bin_d_out, err, 8'(v));
            end
            if (last >= 0) begin
                tests++;
                if (edges - last != 19) begin
                    fails++;
                    $display("FAIL sweep_period value=%0d got %0d want 19",
                             v, edges - last);
                end
            end
            last = edges;
            if (v == 255) begin
                ena = 1'b0;
            end else begin
                tdig = 4'((v + 1) / 100);
                sdig = 4'(((v + 1) / 10) % 10);
                fdig = 4'((v + 1) % 10);
            end
        end
        repeat (3) @(posedge clk);
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_errors();
        test_random();
        test_midchange();
        test_reset_abort();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
